// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin scheduler.
package rr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        COOL = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest requester at or above ptr, else lowest overall.
module rr_pick
    import rr_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int IDXW = idx_width(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic            o_any,
    output logic [IDXW-1:0] o_idx
);

    logic [N-1:0]    w_masked;
    logic            w_mfound;
    logic [IDXW-1:0] w_midx;
    logic [IDXW-1:0] w_uidx;

    always_comb begin
        w_masked = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_masked[i] = i_req[i] && (i >= int'(i_ptr));
        end
    end

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        w_mfound = 1'b0;
        w_midx   = '0;
        w_uidx   = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (w_masked[i-1]) begin
                w_mfound = 1'b1;
                w_midx   = IDXW'(i - 1);
            end
            if (i_req[i-1]) begin
                w_uidx = IDXW'(i - 1);
            end
        end
    end

    assign o_any = |i_req;
    assign o_idx = w_mfound ? w_midx : w_uidx;

endmodule

// File: rtl/rr_sched.sv
// Round-robin scheduler: one registered one-hot grant, held until release,
// holder drop or MAXHOLD cycles, followed by one dead turnaround cycle.
module rr_sched
    import rr_sched_pkg::*;
#(
    parameter int N       = 4,
    parameter int MAXHOLD = 8,
    localparam int IDXW   = idx_width(N),
    localparam int CNTW   = $clog2(MAXHOLD + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            rel,
    output logic [N-1:0]    gnt,
    output logic            gnt_vld,
    output logic [IDXW-1:0] gnt_idx,
    output logic            timeout,
    output logic [CNTW-1:0] hold_cnt
);

    state_t          r_state;
    logic [IDXW-1:0] r_ptr;
    logic [N-1:0]    r_gnt;
    logic            r_gnt_vld;
    logic [IDXW-1:0] r_gnt_idx;
    logic            r_timeout;
    logic [CNTW-1:0] r_hold_cnt;

    logic            w_any;
    logic [IDXW-1:0] w_pick;
    logic            w_hold_done;
    logic            w_holder_req;
    logic            w_exit;
    logic [IDXW-1:0] w_next_ptr;

    rr_pick #(.N(N)) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_pick)
    );

    assign w_hold_done  = (r_hold_cnt == CNTW'(MAXHOLD));
    assign w_holder_req = req[r_gnt_idx];
    assign w_exit       = rel || !w_holder_req || w_hold_done;
    // Wrap at N-1 explicitly so non-power-of-two N never points past the last requester.
    assign w_next_ptr   = (r_gnt_idx == IDXW'(N - 1)) ? '0 : r_gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_gnt_vld  <= 1'b0;
            r_gnt_idx  <= '0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_any) begin
                        r_gnt         <= '0;
                        r_gnt[w_pick] <= 1'b1;
                        r_gnt_vld     <= 1'b1;
                        r_gnt_idx     <= w_pick;
                        r_hold_cnt    <= CNTW'(1);
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_exit) begin
                        r_gnt      <= '0;
                        r_gnt_vld  <= 1'b0;
                        r_gnt_idx  <= '0;
                        r_hold_cnt <= '0;
                        r_ptr      <= w_next_ptr;
                        r_timeout  <= w_hold_done && !rel && w_holder_req;
                        r_state    <= COOL;
                    end else if (!w_hold_done) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                COOL: begin
                    r_timeout <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_timeout <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign gnt_vld  = r_gnt_vld;
    assign gnt_idx  = r_gnt_idx;
    assign timeout  = r_timeout;
    assign hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_rr_sched.sv
// Bench for rr_sched: three configurations (N=4/M=8, N=3/M=4, N=1/M=1) against a
// behavioural owner/hold-count model, with directed scenarios then sticky random traffic.
module tb_rr_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] rq [3];
    logic       rl [3];

    logic [3:0] g4;  logic v4; logic [1:0] x4; logic t4; logic [3:0] h4;
    logic [2:0] g3;  logic v3; logic [1:0] x3; logic t3; logic [2:0] h3;
    logic       g1;  logic v1; logic [0:0] x1; logic t1; logic [0:0] h1;

    rr_sched #(.N(4), .MAXHOLD(8)) u_d4 (
        .clk(clk), .reset(rst), .req(rq[0]), .rel(rl[0]),
        .gnt(g4), .gnt_vld(v4), .gnt_idx(x4), .timeout(t4), .hold_cnt(h4)
    );
    rr_sched #(.N(3), .MAXHOLD(4)) u_d3 (
        .clk(clk), .reset(rst), .req(rq[1][2:0]), .rel(rl[1]),
        .gnt(g3), .gnt_vld(v3), .gnt_idx(x3), .timeout(t3), .hold_cnt(h3)
    );
    rr_sched #(.N(1), .MAXHOLD(1)) u_d1 (
        .clk(clk), .reset(rst), .req(rq[2][0]), .rel(rl[2]),
        .gnt(g1), .gnt_vld(v1), .gnt_idx(x1), .timeout(t1), .hold_cnt(h1)
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int n_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 3 : 1;
    endfunction

    function automatic int mh_of(input int k);
        return (k == 0) ? 8 : (k == 1) ? 4 : 1;
    endfunction

    // Model: owner index (-1 = nobody), cycles held, turnaround flag, pointer.
    int m_own [3];
    int m_cnt [3];
    int m_to  [3];
    int m_ptr [3];
    bit m_cool[3];

    int q4[$];
    int q3[$];
    int tc[3];
    bit pv[3];

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int n  = n_of(k);
            int mh = mh_of(k);
            if (rst) begin
                m_own[k] = -1; m_cnt[k] = 0; m_to[k] = 0; m_ptr[k] = 0; m_cool[k] = 0;
            end else if (m_own[k] >= 0) begin
                bit hreq = rq[k][m_own[k]];
                bit ex   = rl[k] || !hreq || (m_cnt[k] == mh);
                m_to[k] = (ex && m_cnt[k] == mh && !rl[k] && hreq) ? 1 : 0;
                if (ex) begin
                    m_ptr[k]  = (m_own[k] + 1) % n;
                    m_own[k]  = -1;
                    m_cnt[k]  = 0;
                    m_cool[k] = 1;
                end else if (m_cnt[k] < mh) begin
                    m_cnt[k]++;
                end
            end else if (m_cool[k]) begin
                m_cool[k] = 0;
                m_to[k]   = 0;
            end else begin
                bit found = 0;
                m_to[k] = 0;
                for (int off = 0; off < n; off++) begin
                    int j = (m_ptr[k] + off) % n;
                    if (!found && rq[k][j]) begin
                        found    = 1;
                        m_own[k] = j;
                        m_cnt[k] = 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        int og, ov, oi, ot, oh;
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin og = int'(g4); ov = int'(v4); oi = int'(x4); ot = int'(t4); oh = int'(h4); end
                1: begin og = int'(g3); ov = int'(v3); oi = int'(x3); ot = int'(t3); oh = int'(h3); end
                default: begin og = int'(g1); ov = int'(v1); oi = int'(x1); ot = int'(t1); oh = int'(h1); end
            endcase
            chk($sformatf("gnt%0d", k),     og, (m_own[k] >= 0) ? (1 << m_own[k]) : 0);
            chk($sformatf("gnt_vld%0d", k), ov, (m_own[k] >= 0) ? 1 : 0);
            chk($sformatf("gnt_idx%0d", k), oi, (m_own[k] >= 0) ? m_own[k] : 0);
            chk($sformatf("timeout%0d", k), ot, m_to[k]);
            chk($sformatf("hold_cnt%0d", k), oh, m_cnt[k]);
            if (ov != 0 && !pv[k]) begin
                if (k == 0) q4.push_back(oi);
                if (k == 1) q3.push_back(oi);
            end
            pv[k] = (ov != 0);
            if (ot != 0) tc[k]++;
        end
    endtask

    task automatic reset_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q4.delete();
        q3.delete();
        for (int k = 0; k < 3; k++) tc[k] = 0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rq[k] = '0; rl[k] = 1'b0; pv[k] = 1'b0; tc[k] = 0;
            m_own[k] = -1; m_cnt[k] = 0; m_to[k] = 0; m_ptr[k] = 0; m_cool[k] = 0;
        end
        rst = 1'b1;
        step();
        chk("rst_gnt", int'(g4), 0);
        chk("rst_vld", int'(v4), 0);
        chk("rst_idx", int'(x4), 0);
        chk("rst_to",  int'(t4), 0);
        chk("rst_hc",  int'(h4), 0);

        // All requesting, release every busy cycle: strict rotation.
        rq[0] = 4'hf; rq[1] = 4'h7; rq[2] = 4'h1;
        for (int k = 0; k < 3; k++) rl[k] = 1'b1;
        reset_all();
        repeat (14) step();
        for (int i = 0; i < 5; i++)
            chk($sformatf("t1_order%0d", i), (i < q4.size()) ? q4[i] : -1, i % 4);
        chk("t1_no_to", tc[2], 0);

        // Single holder to timeout (N=4), alternating pair (N=3), 1-cycle grants (N=1).
        rq[0] = 4'b0100; rl[0] = 1'b0;
        rq[1] = 4'b0101; rl[1] = 1'b1;
        rq[2] = 4'b0001; rl[2] = 1'b0;
        reset_all();
        repeat (8) step();
        chk("t2_hold8", int'(h4), 8);
        chk("t2_gnt8",  int'(g4), 4);
        chk("t2_to_pre", int'(t4), 0);
        step();
        chk("t2_to",   int'(t4), 1);
        chk("t2_drop", int'(g4), 0);
        repeat (3) step();
        chk("t2_to_cnt", tc[0], 1);
        chk("t2_regrant_n", q4.size(), 2);
        for (int i = 0; i < 2; i++)
            chk($sformatf("t2_regrant%0d", i), (i < q4.size()) ? q4[i] : -1, 2);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_order%0d", i), (i < q3.size()) ? q3[i] : -1, (i % 2 == 0) ? 0 : 2);
        chk("t4_to_cnt", tc[2], 4);

        // Holder 1 drops its request at hold_cnt=3 while requester 3 waits.
        rq[0] = 4'b0010;
        for (int k = 0; k < 3; k++) rl[k] = 1'b0;
        reset_all();
        repeat (3) step();
        chk("t5_hc3", int'(h4), 3);
        rq[0] = 4'b1000;
        repeat (4) step();
        chk("t5_no_to", tc[0], 0);
        chk("t5_first", (q4.size() > 0) ? q4[0] : -1, 1);
        chk("t5_next",  (q4.size() > 1) ? q4[1] : -1, 3);

        // Reset in the middle of a grant.
        rq[0] = 4'b0001;
        reset_all();
        repeat (5) step();
        chk("t6_hc5", int'(h4), 5);
        rst = 1'b1;
        step();
        chk("t6_gnt", int'(g4), 0);
        chk("t6_hc",  int'(h4), 0);
        chk("t6_to",  int'(t4), 0);
        rst = 1'b0;
        rq[0] = 4'b1000;
        step();
        chk("t6_idx", int'(x4), 3);
        chk("t6_gnt3", int'(g4), 8);

        // Sticky random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 3; k++) begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 7) == 0) rq[k][b] = ~rq[k][b];
                rl[k] = ($urandom_range(0, 5) == 0);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
